apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 129 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, then one
// SETUP/ACCESS transfer for the winner, with a bounded ACCESS-phase wait.
module apb_req_arbiter #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         pclk,
  input  logic         preset,
  input  logic [1:0]   req_i,
  input  logic [1:0]   wr_i,
  input  logic [N-1:0] addr0_i,
  input  logic [N-1:0] addr1_i,
  input  logic [N-1:0] wdata0_i,
  input  logic [N-1:0] wdata1_i,
  output logic [1:0]   done_o,
  output logic [N-1:0] rdata_o,
  output logic         err_o,
  output logic         psel_o,
  output logic         penable_o,
  output logic         pwrite_o,
  output logic [N-1:0] paddr_o,
  output logic [N-1:0] pwdata_o,
  input  logic [N-1:0] prdata_i,
  input  logic         pready_i,
  input  logic         pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic [7:0] wait_cnt;

  logic       winner;
  logic       timeout;
  logic       complete;

  // On a tie the requester that did not win last time goes next.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    winner = ~last_grant;
    unique case (req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_grant;
    endcase
  end

  // A cycle with pready_i high is always a normal completion, even on the
  // last allowed wait cycle.
  assign timeout  = (wait_cnt == WAIT_LAST) && !pready_i;
  assign complete = (state == ACCESS) && (pready_i || timeout);

  always_comb begin
    done_o = 2'b00;
    if (complete) done_o[grant] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
      paddr_o    <= '0;
      pwdata_o   <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            state      <= SETUP;
            grant      <= winner;
            last_grant <= winner;
            psel_o     <= 1'b1;
            // The bus registers double as the transfer's latched request.
            if (winner) begin
              pwrite_o <= wr_i[1];
              paddr_o  <= addr1_i;
              pwdata_o <= wr_i[1] ? wdata1_i : '0;
            end else begin
              pwrite_o <= wr_i[0];
              paddr_o  <= addr0_i;
              pwdata_o <= wr_i[0] ? wdata0_i : '0;
            end
          end
        end

        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
          wait_cnt  <= '0;
        end

        ACCESS: begin
          if (complete) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            err_o     <= pready_i ? pslverr_i : 1'b1;
            if (pready_i && !pwrite_o) rdata_o <= prdata_i;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: expected completions are queued when a
// transfer is launched and compared when the DUT pulses done_o.
module tb_apb_req_arbiter;

  localparam int N       = 32;
  localparam int TIMEOUT = 16;

  logic         pclk = 1'b0;
  logic         preset;
  logic [1:0]   req_i, wr_i;
  logic [N-1:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [1:0]   done_o;
  logic [N-1:0] rdata_o;
  logic         err_o, psel_o, penable_o, pwrite_o;
  logic [N-1:0] paddr_o, pwdata_o, prdata_i;
  logic         pready_i, pslverr_i;

  apb_req_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_i     (req_i),
    .wr_i      (wr_i),
    .addr0_i   (addr0_i),
    .addr1_i   (addr1_i),
    .wdata0_i  (wdata0_i),
    .wdata1_i  (wdata1_i),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // waits < 0 means the completer never answers, forcing a timeout.
  task automatic xfer(input logic [1:0] req, input logic [1:0] wr,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input int waits, input logic [31:0] rd,
                      input logic slv, input logic g);
    exp_t        e;
    logic [31:0] ea, ed;
    logic        ew;
    int          cyc;
    bit          got;
    ea = g ? a1 : a0;
    ew = wr[g];
    ed = ew ? (g ? d1 : d0) : 32'h0;
    e.done = g ? 2'b10 : 2'b01;
    e.err  = (waits < 0) ? 1'b1 : slv;
    if (!ew && waits >= 0) model_rdata = rd;
    e.rdata  = model_rdata;
    e.cycles = (waits < 0) ? TIMEOUT : waits + 1;
    sb.push_back(e);

    req_i = req; wr_i = wr; addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
    tick();
    check("setup_psel", psel_o, 1);
    check("setup_penable", penable_o, 0);
    check("setup_paddr", paddr_o, ea);
    check("setup_pwrite", pwrite_o, ew);
    check("setup_pwdata", pwdata_o, ed);
    // Completer response and request fields change mid-flight; none may matter.
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
    addr0_i = ~a0; addr1_i = ~a1; wdata0_i = ~d0; wdata1_i = ~d1; wr_i = ~wr;
    #1;
    check("setup_no_done", done_o, 0);
    tick();

    cyc = 0;
    got = 0;
    while (!got && cyc < TIMEOUT + 3) begin
      cyc++;
      pready_i  = (waits >= 0) && (cyc == waits + 1);
      pslverr_i = pready_i ? slv : 1'b1;
      prdata_i  = pready_i ? rd : (32'hDEAD_0000 | 32'(cyc));
      #1;
      check("access_penable", penable_o, 1);
      check("access_paddr", paddr_o, ea);
      check("access_pwdata", pwdata_o, ed);
      if (done_o != 2'b00) got = 1;
      else tick();
    end

    e = sb.pop_front();
    check("done_pulse", done_o, e.done);
    check("access_cycles", cyc, e.cycles);
    req_i[g] = 1'b0;
    tick();
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    #1;
    check("idle_psel", psel_o, 0);
    check("idle_paddr", paddr_o, 0);
    check("idle_done", done_o, 0);
    check("err", err_o, e.err);
    check("rdata", rdata_o, e.rdata);
  endtask

  initial begin
    preset = 1'b1;
    req_i = '0; wr_i = '0; addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    #1;
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_pwrite", pwrite_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    tick(); tick();
    preset = 1'b0;
    tick();

    // Plain read, ready on first ACCESS cycle.
    xfer(2'b01, 2'b00, 32'hA000, 32'h0, 32'h0, 32'h0, 0, 32'h5, 1'b0, 1'b0);
    // Write from requester 1 with three wait cycles.
    xfer(2'b10, 2'b10, 32'h0, 32'hA004, 32'h0, 32'h6, 3, 32'h77, 1'b0, 1'b1);
    // Contention: both always requesting, grants alternate starting with 0.
    xfer(2'b11, 2'b00, 32'hA100, 32'hA200, 32'h11, 32'h22, 1, 32'h100, 1'b0, 1'b0);
    xfer(2'b11, 2'b11, 32'hA104, 32'hA204, 32'h33, 32'h44, 0, 32'h200, 1'b0, 1'b1);
    xfer(2'b11, 2'b10, 32'hA108, 32'hA208, 32'h55, 32'h66, 2, 32'h300, 1'b0, 1'b0);
    xfer(2'b11, 2'b01, 32'hA10C, 32'hA20C, 32'h77, 32'h88, 0, 32'h400, 1'b0, 1'b1);
    // Timeout on a read: err set, rdata untouched.
    xfer(2'b01, 2'b00, 32'hB000, 32'h0, 32'h0, 32'h0, -1, 32'h99, 1'b0, 1'b0);
    // Slave error on a read: err set, rdata still updated.
    xfer(2'b10, 2'b00, 32'h0, 32'hB004, 32'h0, 32'h0, 2, 32'h1234, 1'b1, 1'b1);
    // Clean write clears err.
    xfer(2'b01, 2'b01, 32'hB008, 32'h0, 32'hCAFE, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    // Ready on the last allowed cycle counts as normal completion.
    xfer(2'b10, 2'b00, 32'h0, 32'hB00C, 32'h0, 32'h0, 15, 32'hBEEF, 1'b0, 1'b1);
    xfer(2'b01, 2'b00, 32'hB010, 32'h0, 32'h0, 32'h0, 0, 32'h4321, 1'b0, 1'b0);

    // Pointer now favours requester 1; abort its transfer with reset.
    req_i = 2'b11; wr_i = 2'b00; addr0_i = 32'hC000; addr1_i = 32'hC004;
    tick();
    check("pre_rst_grant_addr", paddr_o, 32'hC004);
    tick();
    check("pre_rst_penable", penable_o, 1);
    preset = 1'b1; pready_i = 1'b1;
    #1;
    check("abort_psel", psel_o, 0);
    check("abort_penable", penable_o, 0);
    check("abort_done", done_o, 0);
    check("abort_rdata", rdata_o, 0);
    model_rdata = '0;
    @(posedge pclk);
    #1;
    preset = 1'b0; pready_i = 1'b0;
    // First tie after reset goes to requester 0.
    xfer(2'b11, 2'b00, 32'hC100, 32'hC104, 32'h0, 32'h0, 1, 32'h5A5A, 1'b0, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
